// File: rtl/pipelined_byte_ram_pkg.sv
// Shared constants and helpers for pipelined_byte_ram: lane math, latency bound
// and the per-lane even-parity function used on both the write and check paths.
package pipelined_byte_ram_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned MAX_READ_LATENCY   = 4;

    function automatic int unsigned lane_count(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Stored bit makes the lane plus its parity bit carry an even number of ones.
    function automatic logic lane_parity(input logic [7:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/pipelined_byte_ram_read_pipe.sv
// DEPTH-stage valid/data/oor/parity delay line for loads; data holds while no
// valid load passes, and the parity check runs on the last stage.
module ram_read_pipe
    import pipelined_byte_ram_pkg::*;
#(
    parameter int unsigned DEPTH        = 1,
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned LANES        = lane_count(DEFAULT_DATA_WIDTH),
    parameter bit          CHECK_PARITY = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  oor_i,
    input  logic [LANES-1:0]      par_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  oor_o,
    output logic                  par_err_o
);

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      oor_q;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [LANES-1:0]      par_q  [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            oor_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                par_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            oor_q[0]   <= oor_i;
            if (valid_i) begin
                data_q[0] <= data_i;
                par_q[0]  <= par_i;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                oor_q[i]   <= oor_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                    par_q[i]  <= par_q[i-1];
                end
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
    assign oor_o   = oor_q[DEPTH-1];

    generate
        if (CHECK_PARITY) begin : g_check
            logic [LANES-1:0] lane_mis;
            always_comb begin
                lane_mis = '0;
                for (int unsigned i = 0; i < LANES; i++) begin
                    lane_mis[i] = lane_parity(data_q[DEPTH-1][8*i +: 8]) ^ par_q[DEPTH-1][i];
                end
            end
            assign par_err_o = valid_q[DEPTH-1] & ~oor_q[DEPTH-1] & (|lane_mis);
        end else begin : g_no_check
            logic unused_par;
            assign unused_par = ^par_q[DEPTH-1];
            assign par_err_o  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pipelined_byte_ram.sv
// Byte-lane RAM with pipelined loads, readValid strobe and out-of-range pulses.
// Define RAM_PARITY_EN to store/check one even-parity bit per byte lane.
module pipelined_byte_ram
    import pipelined_byte_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned MEM_BYTES    = 65536,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   addressIn,
    input  logic [DATA_WIDTH-1:0]   dataWriteIn,
    input  logic [DATA_WIDTH/8-1:0] byteSelect,
    input  logic                    store,
    input  logic                    load,
    output logic [DATA_WIDTH-1:0]   dataReadOut,
    output logic                    readValid,
    output logic                    addressOutOfRange,
    output logic                    parityError
);

    localparam int unsigned LANES = lane_count(DATA_WIDTH);
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned WORDS = MEM_BYTES / LANES;
    localparam int unsigned IDX_W = clog2_min1(WORDS);
    localparam int unsigned PIPE_DEPTH =
        (READ_LATENCY < 1) ? 1 :
        (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic                  in_range;
    logic [IDX_W-1:0]      word_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [LANES-1:0]      rd_par;
    logic                  ld_oor;
    logic                  st_oor_d;
    logic                  st_oor_q;
    logic                  pipe_oor;

    assign in_range = 64'(addressIn) < 64'(MEM_BYTES);
    assign word_idx = addressIn[OFF_W +: IDX_W];
    assign ld_oor   = load & ~in_range;
    assign st_oor_d = store & ~in_range;

    // Load samples the pre-store word, giving read-before-write on a same-cycle hit.
    always_comb begin
        rd_data = '0;
        if (in_range) begin
            rd_data = mem_q[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (store && in_range) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (byteSelect[i]) begin
                    mem_q[word_idx][8*i +: 8] <= dataWriteIn[8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
    logic [LANES-1:0] par_mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (store && in_range) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (byteSelect[i]) begin
                    par_mem_q[word_idx][i] <= lane_parity(dataWriteIn[8*i +: 8]);
                end
            end
        end
    end

    assign rd_par = in_range ? par_mem_q[word_idx] : '0;
`else
    localparam bit PARITY_EN = 1'b0;
    assign rd_par = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_oor_q <= 1'b0;
        end else begin
            st_oor_q <= st_oor_d;
        end
    end

    ram_read_pipe #(
        .DEPTH        (PIPE_DEPTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .LANES        (LANES),
        .CHECK_PARITY (PARITY_EN)
    ) u_read_pipe (
        .clk_i     (clk),
        .rst_ni    (reset),
        .valid_i   (load),
        .data_i    (rd_data),
        .oor_i     (ld_oor),
        .par_i     (rd_par),
        .valid_o   (readValid),
        .data_o    (dataReadOut),
        .oor_o     (pipe_oor),
        .par_err_o (parityError)
    );

    assign addressOutOfRange = st_oor_q | pipe_oor;

endmodule

// File: tb/tb_pipelined_byte_ram.sv
// Scoreboard bench driving a READ_LATENCY=1 and a READ_LATENCY=3 instance in lockstep.
module tb_pipelined_byte_ram;

    localparam int MB = 65536;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          oor;
        bit          perr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addressIn = '0;
    logic [31:0] dataWriteIn = '0;
    logic [3:0]  byteSelect = '0;
    logic        store = 1'b0;
    logic        load = 1'b0;
    logic [31:0] dout [2];
    logic        rv   [2];
    logic        aoor [2];
    logic        perr [2];

    int          cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;
    exp_t        q   [2][$];
    int          soq [2][$];
    logic [31:0] last_d [2];
    logic [31:0] mdl [int];
    logic [3:0]  bad_lanes [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_byte_ram #(.READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .addressIn(addressIn), .dataWriteIn(dataWriteIn),
        .byteSelect(byteSelect), .store(store), .load(load), .dataReadOut(dout[0]),
        .readValid(rv[0]), .addressOutOfRange(aoor[0]), .parityError(perr[0])
    );

    pipelined_byte_ram #(.READ_LATENCY(3)) u_lat3 (
        .clk(clk), .reset(reset), .addressIn(addressIn), .dataWriteIn(dataWriteIn),
        .byteSelect(byteSelect), .store(store), .load(load), .dataReadOut(dout[1]),
        .readValid(rv[1]), .addressOutOfRange(aoor[1]), .parityError(perr[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        bit          ev, eo, ep;
        logic [31:0] ed;
        for (int k = 0; k < 2; k++) begin
            ev = 1'b0; eo = 1'b0; ep = 1'b0;
            if (!reset) begin
                last_d[k] = '0;
            end else begin
                if (q[k].size() > 0 && q[k][0].due == cyc) begin
                    ev = 1'b1;
                    last_d[k] = q[k][0].data;
                    eo = q[k][0].oor;
                    ep = q[k][0].perr;
                    void'(q[k].pop_front());
                end
                if (soq[k].size() > 0 && soq[k][0] == cyc) begin
                    eo = 1'b1;
                    void'(soq[k].pop_front());
                end
            end
            ed = last_d[k];
            chk($sformatf("readValid[%0d]@%0d", k, cyc), 32'(rv[k]), 32'(ev));
            chk($sformatf("dataReadOut[%0d]@%0d", k, cyc), dout[k], ed);
            chk($sformatf("addressOutOfRange[%0d]@%0d", k, cyc), 32'(aoor[k]), 32'(eo));
            chk($sformatf("parityError[%0d]@%0d", k, cyc), 32'(perr[k]), 32'(ep));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic op(input bit st, input bit ld, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] bs);
        int   acc;
        int   w;
        bit   oor;
        exp_t e;
        acc = cyc + 1;
        w   = int'(a >> 2);
        oor = (a >= 32'(MB));
        if (ld) begin
            e.data = oor ? 32'h0 : mdl[w];
            e.oor  = oor;
            e.perr = 1'b0;
            if (!oor && bad_lanes.exists(w)) e.perr = (bad_lanes[w] != 4'b0000);
            e.due = acc;     q[0].push_back(e);
            e.due = acc + 2; q[1].push_back(e);
        end
        if (st) begin
            if (oor) begin
                soq[0].push_back(acc);
                soq[1].push_back(acc);
            end else begin
                for (int l = 0; l < 4; l++) begin
                    if (bs[l]) begin
                        mdl[w][8*l +: 8] = wd[8*l +: 8];
                        if (bad_lanes.exists(w)) bad_lanes[w][l] = 1'b0;
                    end
                end
            end
        end
        addressIn = a; dataWriteIn = wd; byteSelect = bs; store = st; load = ld;
        tick();
        store = 1'b0; load = 1'b0; byteSelect = '0;
    endtask

    initial begin
        logic [31:0] a;
        idle(3);
        reset = 1'b1;

        op(1, 0, 32'h40, 32'hDEADBEEF, 4'b1111);
        op(0, 1, 32'h40, 32'h0, 4'b0000);
        idle(3);

        op(1, 0, 32'h80, 32'h11223344, 4'b1111);
        op(1, 0, 32'h80, 32'h000000AA, 4'b0001);
        op(0, 1, 32'h80, 32'h0, 4'b0000);
        op(1, 0, 32'h80, 32'hFFFFFFFF, 4'b0000);
        op(1, 0, 32'h80, 32'h5500CC00, 4'b1010);
        op(0, 1, 32'h80, 32'h0, 4'b0000);
        idle(3);

        op(1, 0, 32'h0, 32'hA0A0A0A0, 4'b1111);
        op(1, 0, 32'h4, 32'hB1B1B1B1, 4'b1111);
        op(1, 0, 32'h8, 32'hC2C2C2C2, 4'b1111);
        op(0, 1, 32'h0, 32'h0, 4'b0000);
        op(0, 1, 32'h4, 32'h0, 4'b0000);
        op(0, 1, 32'h8, 32'h0, 4'b0000);
        idle(4);

        op(1, 0, 32'hFFFC, 32'h13579BDF, 4'b1111);
        op(0, 1, 32'hFFFF, 32'h0, 4'b0000);
        op(0, 1, 32'h00010000, 32'h0, 4'b0000);
        idle(4);
        op(1, 0, 32'h00010000, 32'hFFFFFFFF, 4'b1111);
        idle(4);
        op(1, 1, 32'h00010000, 32'h12345678, 4'b1111);
        idle(4);
        op(0, 1, 32'hFFFC, 32'h0, 4'b0000);
        idle(3);

        op(1, 0, 32'hC, 32'h7, 4'b1111);
        op(1, 1, 32'hC, 32'h5, 4'b1111);
        op(0, 1, 32'hC, 32'h0, 4'b0000);
        idle(4);

        for (int i = 0; i < 8; i++) op(1, 0, 32'h200 + 32'(4*i), $urandom, 4'b1111);
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h10000 + 32'(4*i)
                                             : 32'h200 + 32'(4*$urandom_range(0, 7));
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
        end
        idle(4);

        op(0, 1, 32'h0, 32'h0, 4'b0000);
        op(0, 1, 32'h4, 32'h0, 4'b0000);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            soq[k].delete();
        end
        idle(2);
        reset = 1'b1;
        idle(5);
        op(0, 1, 32'h4, 32'h0, 4'b0000);
        idle(4);

`ifdef RAM_PARITY_EN
        op(1, 0, 32'h100, 32'h0, 4'b1111);
        op(1, 0, 32'h100, 32'hFF, 4'b0001);
        idle(1);
        u_lat1.mem_q[64][0] = ~u_lat1.mem_q[64][0];
        u_lat3.mem_q[64][0] = ~u_lat3.mem_q[64][0];
        mdl[64][0] = ~mdl[64][0];
        bad_lanes[64] = 4'b0001;
        op(0, 1, 32'h100, 32'h0, 4'b0000);
        idle(4);
        op(1, 0, 32'h100, 32'hFF, 4'b0001);
        op(0, 1, 32'h100, 32'h0, 4'b0000);
        idle(4);
`endif

        idle(6);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pending_loads[%0d]", k), 32'(q[k].size()), 32'd0);
            chk($sformatf("pending_oor[%0d]", k), 32'(soq[k].size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_byte_ram.md
Name: pipelined_byte_ram

Overview:
- Parametrised successor to the single-cycle byte-select simulation RAM behind the memoryController.
- Provides configurable data width, depth and read latency.
- Fully pipelined loads with an explicit readValid strobe, and registered out-of-range reporting for both loads and stores.
- Sits between memoryController (ramStore/ramLoad/byteSelect side) and the core; one instance per memory region, e.g. main memory or frame buffer.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32: byte-address width.
- MEM_BYTES, 65536: memory size in bytes; must be a multiple of DATA_WIDTH/8.
- READ_LATENCY, 1: cycles from load acceptance to readValid; legal range 1..4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- addressIn  input  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored.
- dataWriteIn  input  DATA_WIDTH  store data.
- byteSelect  input  DATA_WIDTH/8  per-lane store enable.
- store  input  1  store request, one per cycle.
- load  input  1  load request, one per cycle.
- dataReadOut  output  DATA_WIDTH  load data, qualified by readValid.
- readValid  output  1  one-cycle pulse per accepted load.
- addressOutOfRange  output  1  one-cycle error pulse.
- parityError  output  1  lane parity mismatch on a load (see Optional Feature).

Behaviour:
- Reset (reset low, async):
  - dataReadOut=0, readValid=0, addressOutOfRange=0, parityError=0.
  - All in-flight loads flushed.
  - Memory contents are not cleared.
  - Deasserting reset takes effect at the next clk edge.
- Word index = addressIn >> log2(DATA_WIDTH/8). In range iff addressIn < MEM_BYTES.
- Store, in range:
  - At the accepting edge, lanes with byteSelect[i]=1 take dataWriteIn lane i; other lanes keep their old value.
  - byteSelect=0 is a legal no-op.
- Store, out of range: memory unchanged; addressOutOfRange pulses in the cycle after acceptance.
- Load:
  - Memory word sampled at the accepting edge and carried through a READ_LATENCY-deep valid/data shift pipeline.
  - readValid and dataReadOut appear exactly READ_LATENCY cycles after acceptance.
  - Back-to-back loads produce back-to-back readValid pulses, in order; no stalls, no ready signal.
- Load, out of range:
  - readValid still pulses at the normal latency, with dataReadOut=0.
  - addressOutOfRange pulses in the same cycle as that readValid.
- Store and load in the same cycle:
  - Same word: read-before-write; the load returns the old word and the store lands.
  - Store out of range and load in range: addressOutOfRange pulses in the cycle after acceptance for the store.
  - Both out of range: two separate pulses at their respective times (OR-merged if READ_LATENCY=1).
- A store at cycle t followed by a load to the same word at t+1 returns the new data.
- dataReadOut holds its last value while readValid=0.
- Reset asserted mid-operation: pending readValid pulses are lost; stores already accepted remain in memory.

Optional Feature:
- Macro RAM_PARITY_EN.
- Defined:
  - One even-parity bit stored per byte lane, written only for the enabled lanes.
  - On a load, parity is recomputed per lane in the final pipeline stage.
  - parityError pulses with readValid if any lane mismatches; never for out-of-range loads.
- Undefined: no parity storage; parityError tied to 0.

Decomposition:
- Shared package holds:
  - DATA_WIDTH default and lane-count/clog2 helper functions.
  - The READ_LATENCY legality bound (MAX_READ_LATENCY=4).
  - A lane-parity function used by both write and check paths.
- One sub-module, ram_read_pipe:
  - Parametrised DEPTH x (valid, data, oor, parity) delay line with async active-low reset.
  - Instantiated once.

Test Plan:
- Full-word store 0xDEADBEEF to 0x40 with byteSelect=4'b1111, then load 0x40 (READ_LATENCY=1) -> readValid one cycle later, dataReadOut=0xDEADBEEF.
- Store 0x000000AA with byteSelect=4'b0001 over 0x11223344 at 0x80, then load 0x80 -> 0x112233AA.
- READ_LATENCY=3, loads to 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive readValid pulses starting 3 cycles after the first load, data in order.
- Load 0x00010000 (MEM_BYTES=65536) -> readValid at the normal latency, dataReadOut=0, addressOutOfRange in the same cycle. Store to the same address -> memory unchanged, addressOutOfRange one cycle later.
- Same-cycle store 0x5 / load at 0xC holding 0x7 -> load returns 0x7; a follow-up load returns 0x5. Reset low while two loads are in flight -> no readValid after release.
- RAM_PARITY_EN: store 0xFF at lane 0, flip one stored bit hierarchically, load -> parityError=1 with readValid. Clean reload after rewrite -> parityError=0.
